lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory port. Accepts one memory operation at a time, checks alignment, and drives a request/grant/response handshake to data memory with word-aligned address, byte enables and lane-replicated write data. For loads it registers the raw memory word and holds the access type and low address bits stable for `select_rd`, which extracts and extends the result. It also provides the pipeline stall, the completion pulse and the error reporting.

## Interface
- `TIMEOUT`, 16: max cycles in WAIT before abort; counter width `$clog2(TIMEOUT+1)`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents an operation.
- `req_ready`  out  1  controller can accept; `state==IDLE`, combinational.
- `req_we`  in  1  1 = store, 0 = load.
- `req_type`  in  3  access type: SB 000, SH 001, SW 010, SBU 011, SHU 100.
- `req_addr`  in  `REG_LEN`  byte address.
- `req_wdata`  in  `REG_LEN`  store data, value in the low bits.
- `mem_req`  out  1  request to memory; held until `mem_gnt`.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  `REG_LEN`  `{req_addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  `REG_LEN`  replicated store data.
- `mem_gnt`  in  1  memory accepted request.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  `REG_LEN`  load word.
- `rdata`  out  `REG_LEN`  latched word to `select_rd.rdata`.
- `sel_type`  out  3  latched type to `select_rd.sel_type`.
- `sel_addr_old`  out  2  latched `req_addr[1:0]` to `select_rd.sel_addr_old`.
- `done`  out  1  one-cycle pulse: operation complete, `rdata` valid for loads.
- `err`  out  1  one-cycle pulse: misaligned access or timeout.
- `stall`  out  1  `~req_ready & req_valid`.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: on `req_valid`, latch `we`, `type`, `addr[1:0]`, compute `mem_addr`/`mem_be`/`mem_wdata`.
  - Misaligned (SH/SHU with `addr[0]=1`; SW with `addr[1:0]!=0`): no memory access, `err` pulses next cycle, stay IDLE.
  - Otherwise go to REQ with `mem_req=1` registered.
- REQ: hold all `mem_*` stable until `mem_gnt`. On grant, `mem_req` drops. A store goes to IDLE and pulses `done`; a load goes to WAIT and clears the timeout counter.
- WAIT: `mem_rvalid` is ignored before entering WAIT. On `mem_rvalid`, latch `rdata` and go to IDLE; `done` pulses with the new `rdata`. If the counter reaches `TIMEOUT`, pulse `err`, leave `rdata` unchanged and go to IDLE.
- Byte enables: SB/SBU `4'b0001<<addr[1:0]`; SH/SHU `4'b0011<<{addr[1],1'b0}`; SW `4'b1111`.
- Write data: SB/SBU `{4{wdata[7:0]}}`; SH/SHU `{2{wdata[15:0]}}`; SW unchanged. For stores, SBU is treated as SB and SHU as SH.
- `sel_type` and `sel_addr_old` change only on accept and are held until the next accept.
- An undefined `req_type` (101–111) is treated as misaligned: `err` pulses.

## Timing
- Reset values: state IDLE, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `rdata`, `done`, `err` all 0; `sel_type` 010; `sel_addr_old` 00. `req_ready` is 1 after reset.
- Reset mid-operation: the state returns to IDLE on the edge where `rst` is sampled, and `mem_req` is low in the following cycle. The in-flight response is dropped; a late `mem_rvalid` in IDLE is ignored.
- Best-case latency, with accept at edge 0:
  - Store: `mem_req` high in cycle 1, with `gnt` in cycle 1 → `done` in cycle 2.
  - Load: `mem_req` in cycle 1, `gnt` in cycle 1, `rvalid` in cycle 2 → `done` and `rdata` in cycle 3.
- Throughput: a new accept is possible in the same cycle that `done` is high.
- `done` and `err` are never high together.

## Structure
- `rysy_pkg.vh` holds the SB/SH/SW/SBU/SHU codes (shared with `select_rd`), `REG_LEN`, and the state encodings.
- One combinational sub-module, `lsu_be_gen`: inputs type and `addr[1:0]`; outputs `be`, the replicated write data, and the misalign flag.

## Test plan
- Store SB, addr 0x103, wdata 0xAB, gnt immediate → `mem_addr` 0x100, `be` 1000, `mem_wdata` 0xABABABAB, `done` at cycle 2.
- Load SHU, addr 0x202, gnt after 3 cycles, `rvalid` with 0x12345678 → `mem_req` held 3 cycles, `rdata` 0x12345678, `sel_type` 100, `sel_addr_old` 10; `select_rd` output 0x00001234.
- Load SW at addr 0x301 → no `mem_req`; `err` pulses at cycle 1; `req_ready` stays 1.
- Load SB, `rvalid` never arrives, `TIMEOUT`=16 → `err` 16 cycles after entering WAIT, then IDLE; a late `rvalid` is ignored.
- Assert `rst` while in WAIT → state IDLE and `mem_req` 0 the next cycle; `rdata` 0, `sel_type` 010.
- Back-to-back SH store to 0x10 followed by a load: second accept in the `done` cycle; `be` 0011 then per the load type.

Source files
------------

// File: rtl/rysy_pkg.sv
// rtl/rysy_pkg.sv - shared access-type codes, register width and LSU state encoding
package rysy_pkg;

  localparam int REG_LEN = 32;

  // Access-type codes shared with select_rd
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;
  localparam logic [2:0] LSU_SBU = 3'b011;
  localparam logic [2:0] LSU_SHU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_be_gen.sv
// rtl/lsu_be_gen.sv - byte enables, lane-replicated write data and misalign flag
module lsu_be_gen
  import rysy_pkg::*;
(
  input  logic [2:0]         acc_type,
  input  logic [1:0]         addr_lo,
  input  logic [REG_LEN-1:0] wdata,
  output logic [3:0]         be,
  output logic [REG_LEN-1:0] wdata_rep,
  output logic               misalign
);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (acc_type)
      LSU_SB, LSU_SBU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      LSU_SH, LSU_SHU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      LSU_SW: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      // Undefined type codes are rejected like a misaligned access
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between execute stage and data-memory port
module lsu_ctrl
  import rysy_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_type,
  input  logic [REG_LEN-1:0] req_addr,
  input  logic [REG_LEN-1:0] req_wdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [REG_LEN-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [REG_LEN-1:0] mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [REG_LEN-1:0] mem_rdata,
  output logic [REG_LEN-1:0] rdata,
  output logic [2:0]         sel_type,
  output logic [1:0]         sel_addr_old,
  output logic               done,
  output logic               err,
  output logic               stall
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mem_req_d, mem_we_d, done_d, err_d;
  logic [REG_LEN-1:0] mem_addr_d, mem_wdata_d, rdata_d;
  logic [3:0]         mem_be_d;
  logic [2:0]         sel_type_d;
  logic [1:0]         sel_addr_old_d;

  logic [3:0]         gen_be;
  logic [REG_LEN-1:0] gen_wdata;
  logic               gen_misalign;

  lsu_be_gen u_be_gen (
    .acc_type  (req_type),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (gen_be),
    .wdata_rep (gen_wdata),
    .misalign  (gen_misalign)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign stall     = ~req_ready & req_valid;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req;
    mem_we_d       = mem_we;
    mem_addr_d     = mem_addr;
    mem_be_d       = mem_be;
    mem_wdata_d    = mem_wdata;
    rdata_d        = rdata;
    sel_type_d     = sel_type;
    sel_addr_old_d = sel_addr_old;
    done_d         = 1'b0;
    err_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sel_type_d     = req_type;
          sel_addr_old_d = req_addr[1:0];
          if (gen_misalign) begin
            err_d = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[REG_LEN-1:2], 2'b00};
            mem_be_d    = gen_be;
            mem_wdata_d = gen_wdata;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A response arriving on the final waiting cycle still wins over the timeout
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= 4'b0000;
      mem_wdata    <= '0;
      rdata        <= '0;
      sel_type     <= LSU_SW;
      sel_addr_old <= 2'b00;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_be       <= mem_be_d;
      mem_wdata    <= mem_wdata_d;
      rdata        <= rdata_d;
      sel_type     <= sel_type_d;
      sel_addr_old <= sel_addr_old_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule
